// File: rtl/sysclk_ctrl.sv
// sysclk_ctrl: CPU clock divider, delayed CPU reset and periodic timer channels with a combined IRQ
module sysclk_ctrl #(
  parameter int          OSC_CLOCK  = 12000000,
  parameter int          CPU_CLOCK  = 2000000,
  parameter int          RES_DELAY  = 4,
  parameter int          NCH        = 2,
  parameter logic [23:0] DEF_RELOAD = 24'd239999
) (
  input  logic           clk_in,
  input  logic           b_reset,
  output logic           sys_clk,
  output logic           sys_res,
  input  logic           cs,
  input  logic           rw,
  input  logic [3:0]     Address,
  input  logic [7:0]     DI,
  output logic [7:0]     DO,
  output logic           irq,
  output logic [NCH-1:0] tick
);
  localparam int          CLK_DIV_PERIOD = (OSC_CLOCK / CPU_CLOCK) / 2;
  localparam logic [23:0] DIV_LAST       = 24'(CLK_DIV_PERIOD - 1);
  localparam logic [7:0]  RES_INIT       = 8'(RES_DELAY);
  logic [23:0]    div_q, div_d;
  logic           sys_clk_q, sys_clk_d, sys_res_q, sys_res_d, irq_q, irq_d;
  logic [7:0]     rdly_q, rdly_d;
  logic [NCH-1:0] ctrl_q, ctrl_d, pend_q, pend_d, tick_q, tick_d, clr;
  logic [23:0]    reload_q [NCH];
  logic [23:0]    reload_d [NCH];
  logic [23:0]    tcnt_q [NCH];
  logic [23:0]    tcnt_d [NCH];
  logic           div_wrap, rise_en, wr, sw_rst;
  logic [7:0]     rd_data;
  always_comb begin
    div_wrap  = div_q == DIV_LAST;
    rise_en   = div_wrap & ~sys_clk_q;
    div_d     = div_wrap ? '0 : div_q + 24'd1;
    sys_clk_d = sys_clk_q ^ div_wrap;
    wr        = rise_en & cs & ~rw & ~sys_res_q;
    sw_rst    = wr && Address == 4'd0 && DI[7];
    rdly_d    = sw_rst ? RES_INIT : (rise_en && rdly_q != 8'd0) ? rdly_q - 8'd1 : rdly_q;
    sys_res_d = sw_rst | (sys_res_q & ~(rise_en & (rdly_q == 8'd0)));
    ctrl_d    = sw_rst ? '0 : (wr && Address == 4'd0) ? DI[NCH-1:0] : ctrl_q;
    clr       = (wr && Address == 4'd1) ? DI[NCH-1:0] : '0;
    irq_d     = |(pend_q & ctrl_q);
    tick_d    = '0;
    for (int c = 0; c < NCH; c++) begin
      tick_d[c]   = ctrl_q[c] && tcnt_q[c] == 24'd0;
      // a disabled channel tracks its reload so a new value applies on enable
      tcnt_d[c]   = (!ctrl_q[c] || tick_d[c]) ? reload_q[c] : tcnt_q[c] - 24'd1;
      reload_d[c] = reload_q[c];
      for (int b = 0; b < 3; b++)
        if (wr && int'(Address) == 4 * c + 4 + b) reload_d[c][8*b +: 8] = DI;
    end
    pend_d = sw_rst ? '0 : (pend_q & ~clr) | tick_d;
  end
  always_comb begin
    rd_data = '0;
    if (Address == 4'd0) rd_data[NCH-1:0] = ctrl_q;
    if (Address == 4'd1) rd_data[NCH-1:0] = pend_q;
    for (int c = 0; c < NCH; c++)
      for (int b = 0; b < 3; b++)
        if (int'(Address) == 4 * c + 4 + b) rd_data = reload_q[c][8*b +: 8];
  end
  always_ff @(posedge clk_in or negedge b_reset)
    if (!b_reset) begin
      div_q     <= '0;
      sys_clk_q <= 1'b0;
      sys_res_q <= 1'b1;
      rdly_q    <= RES_INIT;
      irq_q     <= 1'b0;
      ctrl_q    <= '0;
      pend_q    <= '0;
      tick_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        reload_q[c] <= DEF_RELOAD;
        tcnt_q[c]   <= DEF_RELOAD;
      end
    end else begin
      div_q     <= div_d;
      sys_clk_q <= sys_clk_d;
      sys_res_q <= sys_res_d;
      rdly_q    <= rdly_d;
      irq_q     <= irq_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      for (int c = 0; c < NCH; c++) begin
        reload_q[c] <= reload_d[c];
        tcnt_q[c]   <= tcnt_d[c];
      end
    end
  assign sys_clk = sys_clk_q;
  assign sys_res = sys_res_q;
  assign irq     = irq_q;
  assign tick    = tick_q;
  assign DO      = rd_data;
endmodule

// File: tb/tb_sysclk_ctrl.sv
// tb_sysclk_ctrl: directed scenarios for sysclk_ctrl with default parameters (divide-by-6, 4-rise reset delay)
module tb_sysclk_ctrl;
  logic       clk_in = 1'b0, b_reset = 1'b0, cs = 1'b0, rw = 1'b1;
  logic [3:0] Address = '0;
  logic [7:0] DI = '0;
  logic       sys_clk, sys_res, irq;
  logic [7:0] DO;
  logic [1:0] tick;
  int         k = 0, total = 0, bad = 0, e = 0;
  logic [7:0] exp8;

  sysclk_ctrl dut (
    .clk_in(clk_in), .b_reset(b_reset), .sys_clk(sys_clk), .sys_res(sys_res),
    .cs(cs), .rw(rw), .Address(Address), .DI(DI), .DO(DO), .irq(irq), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  // k counts clk_in rising edges since the last b_reset release
  task automatic step();
    @(posedge clk_in);
    #2;
    k++;
  endtask

  // sys_clk rises on edges with k%6==3; bus writes are only taken on those edges
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    while ((k + 1) % 6 != 3) step();
    cs = 1'b1; rw = 1'b0; Address = a; DI = d;
    step();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (sys_clk !== 1'b0) begin bad++; $display("FAIL rst_sys_clk got=%b want=0", sys_clk); end
    total++; if (sys_res !== 1'b1) begin bad++; $display("FAIL rst_sys_res got=%b want=1", sys_res); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", irq); end
    total++; if (tick !== 2'b00) begin bad++; $display("FAIL rst_tick got=%b want=00", tick); end
    Address = 4'd4; #1;
    total++; if (DO !== 8'h7F) begin bad++; $display("FAIL rst_reload0_b0 got=%h want=7f", DO); end
    Address = 4'd6; #1;
    total++; if (DO !== 8'h03) begin bad++; $display("FAIL rst_reload0_b2 got=%h want=03", DO); end
    Address = 4'd9; #1;
    total++; if (DO !== 8'hA9) begin bad++; $display("FAIL rst_reload1_b1 got=%h want=a9", DO); end
    Address = 4'd0; #1;
    total++; if (DO !== 8'h00) begin bad++; $display("FAIL rst_ctrl got=%h want=00", DO); end
    b_reset = 1'b1;
    k = 0;
  endtask

  task automatic test_divider();
    while (k < 40) begin
      step();
      total++; if (sys_clk !== ((k / 3) % 2 == 1)) begin bad++; $display("FAIL div_sys_clk k=%0d got=%b", k, sys_clk); end
      total++; if (sys_res !== (k < 27)) begin bad++; $display("FAIL seq_sys_res k=%0d got=%b want=%b", k, sys_res, k < 27); end
    end
  endtask

  task automatic test_timer();
    bus_write(4'd4, 8'd9);
    bus_write(4'd5, 8'd0);
    bus_write(4'd6, 8'd0);
    Address = 4'd4; #1;
    total++; if (DO !== 8'd9) begin bad++; $display("FAIL reload_rd got=%h want=09", DO); end
    bus_write(4'd0, 8'h01);
    e = k;
    Address = 4'd1;
    repeat (30) begin
      step();
      exp8 = (k - e >= 10) ? 8'h01 : 8'h00;
      total++; if (tick[0] !== ((k - e) % 10 == 0)) begin bad++; $display("FAIL tmr_tick k=%0d got=%b", k, tick[0]); end
      total++; if (tick[1] !== 1'b0) begin bad++; $display("FAIL tmr_tick1 k=%0d got=%b want=0", k, tick[1]); end
      total++; if (DO !== exp8) begin bad++; $display("FAIL tmr_status k=%0d got=%h want=%h", k, DO, exp8); end
      total++; if (irq !== (k - e >= 11)) begin bad++; $display("FAIL tmr_irq k=%0d got=%b", k, irq); end
    end
  endtask

  task automatic test_w1c();
    while (k < 122) step();
    bus_write(4'd1, 8'h01);
    Address = 4'd1; #1;
    total++; if (k !== 123 || tick[0] !== 1'b1) begin bad++; $display("FAIL w1c_coincide_setup k=%0d tick=%b", k, tick[0]); end
    total++; if (DO !== 8'h01) begin bad++; $display("FAIL w1c_set_wins got=%h want=01", DO); end
    bus_write(4'd1, 8'h01);
    Address = 4'd1; #1;
    total++; if (DO !== 8'h00) begin bad++; $display("FAIL w1c_clear got=%h want=00", DO); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b want=1", irq); end
    step();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop got=%b want=0", irq); end
    while (k < 133) step();
    total++; if (DO !== 8'h01) begin bad++; $display("FAIL w1c_reset_again got=%h want=01", DO); end
  endtask

  task automatic test_reload_change();
    bus_write(4'd4, 8'd4);
    while (k < 160) begin
      step();
      total++; if (tick[0] !== (k == 143 || k == 148 || k == 153 || k == 158)) begin bad++; $display("FAIL reload_chg_tick k=%0d got=%b", k, tick[0]); end
    end
  endtask

  task automatic test_sw_reset();
    bus_write(4'd0, 8'h80);
    total++; if (sys_res !== 1'b1) begin bad++; $display("FAIL swrst_sys_res got=%b want=1", sys_res); end
    Address = 4'd0; #1;
    total++; if (DO !== 8'h00) begin bad++; $display("FAIL swrst_ctrl got=%h want=00", DO); end
    Address = 4'd1; #1;
    total++; if (DO !== 8'h00) begin bad++; $display("FAIL swrst_status got=%h want=00", DO); end
    bus_write(4'd0, 8'h01);
    bus_write(4'd4, 8'h55);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL swrst_irq got=%b want=0", irq); end
    while (k < 196) begin
      step();
      total++; if (sys_res !== (k < 195)) begin bad++; $display("FAIL swrst_seq k=%0d got=%b want=%b", k, sys_res, k < 195); end
      total++; if (tick !== 2'b00) begin bad++; $display("FAIL swrst_tick k=%0d got=%b want=00", k, tick); end
    end
    Address = 4'd0; #1;
    total++; if (DO !== 8'h00) begin bad++; $display("FAIL swrst_ignored_ctrl got=%h want=00", DO); end
    Address = 4'd4; #1;
    total++; if (DO !== 8'h04) begin bad++; $display("FAIL swrst_reload_kept got=%h want=04", DO); end
    Address = 4'd5; #1;
    total++; if (DO !== 8'h00) begin bad++; $display("FAIL swrst_reload_b1 got=%h want=00", DO); end
  endtask

  task automatic test_async_reset();
    bus_write(4'd0, 8'h01);
    while (k < 213) step();
    total++; if (sys_clk !== 1'b1) begin bad++; $display("FAIL arst_pre_sys_clk got=%b want=1", sys_clk); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL arst_pre_irq got=%b want=1", irq); end
    b_reset = 1'b0; #1;
    total++; if (sys_clk !== 1'b0) begin bad++; $display("FAIL arst_sys_clk got=%b want=0", sys_clk); end
    total++; if (sys_res !== 1'b1) begin bad++; $display("FAIL arst_sys_res got=%b want=1", sys_res); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b want=0", irq); end
    Address = 4'd4; #1;
    total++; if (DO !== 8'h7F) begin bad++; $display("FAIL arst_reload_b0 got=%h want=7f", DO); end
    Address = 4'd5; #1;
    total++; if (DO !== 8'hA9) begin bad++; $display("FAIL arst_reload_b1 got=%h want=a9", DO); end
    Address = 4'd0; #1;
    total++; if (DO !== 8'h00) begin bad++; $display("FAIL arst_ctrl got=%h want=00", DO); end
    step(); step();
    b_reset = 1'b1;
    k = 0;
    while (k < 8) begin
      step();
      total++; if (sys_clk !== ((k / 3) % 2 == 1)) begin bad++; $display("FAIL arst_restart k=%0d got=%b", k, sys_clk); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog k=%0d", k);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divider();
    test_timer();
    test_w1c();
    test_reload_change();
    test_sw_reset();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
